// File: rtl/cam_i2c_pkg.sv
// Shared types and constants for the camera I2C write arbiter.
package cam_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOW  = 2'd1,
    ST_WAIT_HIGH = 2'd2,
    ST_FINISH    = 2'd3
  } state_t;

  localparam int DEF_START_TO = 16;
  localparam int DEF_XFER_TO  = 256;
  localparam int ADDR_W       = 8;
  localparam int REG_W        = 16;
  localparam int DATA_W       = 8;
  localparam int MAX_REQ      = 4;
  localparam int IDX_W        = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_i2c_rr_pick.sv
// Round-robin picker: first set request searching upward from last_grant+1.
module cam_i2c_rr_pick
  import cam_i2c_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] grant
);

  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   cand;

  // Walk from the lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    req_ext = MAX_REQ'(req);
    valid   = 1'b0;
    grant   = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand  = IDX_W'((int'(last_grant) + k) % N_REQ);
      grant = req_ext[cand] ? cand : grant;
      valid = valid | req_ext[cand];
    end
  end

endmodule

// File: rtl/cam_i2c_arbiter.sv
// Shares one camera I2C master among N_REQ register-write requesters,
// round-robin, with start/transfer timeouts on the master's ready line.
module cam_i2c_arbiter
  import cam_i2c_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int START_TO = DEF_START_TO,
  parameter int XFER_TO  = DEF_XFER_TO
) (
  input  logic                      clk400,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [ADDR_W*N_REQ-1:0]   req_slave_addr,
  input  logic [REG_W*N_REQ-1:0]    req_register,
  input  logic [DATA_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic                      send_data,
  output logic [ADDR_W-1:0]         slave_addr,
  output logic [REG_W-1:0]          register_in,
  output logic [DATA_W-1:0]         datain,
  input  logic                      ready,
  output logic                      busy
);

  localparam int TW = $clog2(max_int(START_TO, XFER_TO));
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TO - 1);

  state_t           state, state_next;
  logic [TW-1:0]    timer, timer_next, timer_inc;
  logic [IDX_W-1:0] gnt, gnt_next, last_grant, last_next, pick_idx;
  logic             pick_valid, ready_meta, ready_s, load, send_next;
  logic [N_REQ-1:0] ack_next, done_next, err_next;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  cam_i2c_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_idx)
  );

  // Next-state and pulse decode; completion pulses are registered on entry to FINISH.
  always_comb begin
    state_next = state;
    timer_next = timer;
    gnt_next   = gnt;
    last_next  = last_grant;
    ack_next   = '0;
    done_next  = '0;
    err_next   = '0;
    send_next  = 1'b0;
    load       = 1'b0;
    timer_inc  = (timer == '1) ? timer : timer + TW'(1);
    case (state)
      ST_IDLE: begin
        if (ready_s && pick_valid) begin
          load       = 1'b1;
          gnt_next   = pick_idx;
          last_next  = pick_idx;
          ack_next   = onehot(pick_idx);
          send_next  = 1'b1;
          timer_next = '0;
          state_next = ST_WAIT_LOW;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_LOW: begin
        if (!ready_s) begin
          timer_next = '0;
          state_next = ST_WAIT_HIGH;
        end else if (timer == START_LAST) begin
          done_next  = onehot(gnt);
          err_next   = onehot(gnt);
          state_next = ST_FINISH;
        end else begin
          timer_next = timer_inc;
        end
      end
      ST_WAIT_HIGH: begin
        if (ready_s) begin
          done_next  = onehot(gnt);
          state_next = ST_FINISH;
        end else if (timer == XFER_LAST) begin
          done_next  = onehot(gnt);
          err_next   = onehot(gnt);
          state_next = ST_FINISH;
        end else begin
          timer_next = timer_inc;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, synchronizer, registered outputs and held master fields.
  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      ready_meta  <= 1'b0;
      ready_s     <= 1'b0;
      state       <= ST_IDLE;
      timer       <= '0;
      gnt         <= '0;
      last_grant  <= IDX_W'(N_REQ - 1);
      ack         <= '0;
      done        <= '0;
      err         <= '0;
      send_data   <= 1'b0;
      busy        <= 1'b0;
      slave_addr  <= '0;
      register_in <= '0;
      datain      <= '0;
    end else begin
      ready_meta <= ready;
      ready_s    <= ready_meta;
      state      <= state_next;
      timer      <= timer_next;
      gnt        <= gnt_next;
      last_grant <= last_next;
      ack        <= ack_next;
      done       <= done_next;
      err        <= err_next;
      send_data  <= send_next;
      busy       <= (state_next != ST_IDLE);
      if (load) begin
        slave_addr  <= req_slave_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        register_in <= req_register[int'(pick_idx)*REG_W +: REG_W];
        datain      <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
      end else begin
        slave_addr  <= slave_addr;
        register_in <= register_in;
        datain      <= datain;
      end
    end
  end

endmodule
